pc_fetch_unit: RTL and testbench

Parametrised program-counter unit and the successor to the plain PC register. It holds the PC and drives instruction-memory fetch requests over a valid/ready handshake. It supports stall, branch/jump redirect, trap entry, halt/resume and misaligned-target detection. It sits between the core control path (branch unit, trap logic) and the instruction-memory interface.

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_next_sel.sv | 40 ++++
 rtl/pc_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter fetch unit.
// Holds the FSM state encoding, default vectors and the alignment-mask helper.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    // Low address bits that must be zero for a legal instruction address.
    function automatic logic [1:0] align_mask(input int ialign);
        return (ialign == 16) ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority mux choosing the next PC value:
// reset > trap > redirect > pending > increment, else hold.
module pc_next_sel #(
    parameter int XLEN = 32
) (
    input  logic            i_reset,
    input  logic            i_trap,
    input  logic            i_redir,
    input  logic            i_pend_valid,
    input  logic            i_held,
    input  logic            i_accept,
    input  logic [XLEN-1:0] i_reset_vec,
    input  logic [XLEN-1:0] i_trap_vec,
    input  logic [XLEN-1:0] i_redir_target,
    input  logic [XLEN-1:0] i_pend_target,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_plus,
    output logic [XLEN-1:0] o_pc_next
);

    // Trap/redirect load the PC directly only when no request is held or the held one completes now.
    logic w_direct_ok;
    assign w_direct_ok = !i_held || i_accept;

    always_comb begin
        o_pc_next = i_pc;
        if (i_reset) begin
            o_pc_next = i_reset_vec;
        end else if (i_trap && w_direct_ok) begin
            o_pc_next = i_trap_vec;
        end else if (i_redir && w_direct_ok) begin
            o_pc_next = i_redir_target;
        end else if (i_accept && i_pend_valid) begin
            o_pc_next = i_pend_target;
        end else if (i_accept) begin
            o_pc_next = i_pc_plus;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter unit driving instruction fetch over valid/ready, with stall,
// redirect, trap entry, halt/resume and misaligned-redirect detection.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int              IALIGN       = 32,
    parameter int              STEP         = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_req,
    input  logic            halt_req,
    input  logic            resume,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] pc_plus_step,
    output logic            halted,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(IALIGN));

    if (IALIGN != 16 && IALIGN != 32) begin : g_bad_ialign
        $error("pc_fetch_unit: IALIGN must be 16 or 32");
    end
    if ((RESET_VECTOR & ALIGN_MASK) != '0) begin : g_bad_reset_vec
        $error("pc_fetch_unit: RESET_VECTOR is misaligned");
    end
    if ((TRAP_VECTOR & ALIGN_MASK) != '0) begin : g_bad_trap_vec
        $error("pc_fetch_unit: TRAP_VECTOR is misaligned");
    end

    pc_state_e       r_state;
    pc_state_e       w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_target;
    logic            r_pend_valid;
    logic            r_pend_trap;
    logic            r_held;
    logic            r_misalign_exc;
    logic [XLEN-1:0] r_misalign_addr;

    logic            w_valid;
    logic            w_halted;
    logic            w_accept;
    logic            w_aligned;
    logic            w_redir_eff;
    logic            w_misalign;
    logic [XLEN-1:0] w_pc_plus;
    logic [XLEN-1:0] w_pc_next;

    assign w_pc_plus = r_pc + XLEN'(STEP);
    assign w_accept  = w_valid && imem_req_ready;
    assign w_aligned = (redirect_target & ALIGN_MASK) == '0;

    // A pending trap must not be displaced by a later redirect.
    assign w_redir_eff = redirect_valid && w_aligned && (r_state != HALT)
                         && !(r_held && r_pend_valid && r_pend_trap);
    assign w_misalign  = redirect_valid && !w_aligned && !trap_req && (r_state != HALT);

    pc_next_sel #(
        .XLEN (XLEN)
    ) u_next_sel (
        .i_reset        (reset),
        .i_trap         (trap_req),
        .i_redir        (w_redir_eff),
        .i_pend_valid   (r_pend_valid),
        .i_held         (r_held),
        .i_accept       (w_accept),
        .i_reset_vec    (RESET_VECTOR),
        .i_trap_vec     (TRAP_VECTOR),
        .i_redir_target (redirect_target),
        .i_pend_target  (r_pend_target),
        .i_pc           (r_pc),
        .i_pc_plus      (w_pc_plus),
        .o_pc_next      (w_pc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Halt waits until no request would be left outstanding across the edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:    w_state_next = RUN;
            RUN:     if (halt_req && !(w_valid && !imem_req_ready)) w_state_next = HALT;
            HALT:    if (trap_req || resume) w_state_next = RUN;
            default: w_state_next = BOOT;
        endcase
    end

    always_comb begin
        w_valid  = (r_state == RUN) && (!stall || r_held);
        w_halted = (r_state == HALT);
    end

    always_ff @(posedge clk) begin
        r_pc <= w_pc_next;
        if (reset) begin
            r_held          <= 1'b0;
            r_pend_valid    <= 1'b0;
            r_pend_trap     <= 1'b0;
            r_pend_target   <= '0;
            r_misalign_exc  <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_held         <= w_valid && !imem_req_ready;
            r_misalign_exc <= w_misalign;
            if (w_misalign) begin
                r_misalign_addr <= redirect_target;
            end
            // Pending only lives while a request is held and not yet accepted.
            if (w_accept || !r_held) begin
                r_pend_valid <= 1'b0;
                r_pend_trap  <= 1'b0;
            end else if (trap_req) begin
                r_pend_valid  <= 1'b1;
                r_pend_trap   <= 1'b1;
                r_pend_target <= TRAP_VECTOR;
            end else if (w_redir_eff) begin
                r_pend_valid  <= 1'b1;
                r_pend_trap   <= 1'b0;
                r_pend_target <= redirect_target;
            end
        end
    end

    assign imem_req_valid = w_valid;
    assign imem_addr      = r_pc;
    assign pc_plus_step   = w_pc_plus;
    assign halted         = w_halted;
    assign misalign_exc   = r_misalign_exc;
    assign misalign_addr  = r_misalign_addr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: one IALIGN=32 instance checked throughout,
// plus an IALIGN=16 instance sharing the inputs for the alignment scenario.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_req;
    logic        halt_req;
    logic        resume;
    logic        imem_req_ready;

    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic [31:0] pc_plus_step;
    logic        halted;
    logic        misalign_exc;
    logic [31:0] misalign_addr;

    logic        d16_valid;
    logic [31:0] d16_addr;
    logic [31:0] d16_plus;
    logic        d16_halted;
    logic        d16_mexc;
    logic [31:0] d16_maddr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.IALIGN(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .halt_req        (halt_req),
        .resume          (resume),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .pc_plus_step    (pc_plus_step),
        .halted          (halted),
        .misalign_exc    (misalign_exc),
        .misalign_addr   (misalign_addr)
    );

    pc_fetch_unit #(.IALIGN(16)) dut16 (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .halt_req        (halt_req),
        .resume          (resume),
        .imem_req_valid  (d16_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (d16_addr),
        .pc_plus_step    (d16_plus),
        .halted          (d16_halted),
        .misalign_exc    (d16_mexc),
        .misalign_addr   (d16_maddr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        trap_req = 1'b0; halt_req = 1'b0; resume = 1'b0; imem_req_ready = 1'b1;
        step(); step();
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", imem_req_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", halted); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        checks++; if (misalign_exc !== 1'b0 || misalign_addr !== 32'h0) begin failures++; $display("FAIL rst_misalign got=%b/%h exp=0/0", misalign_exc, misalign_addr); end
        reset = 1'b0; #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", imem_req_valid); end
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL run_addr0 got=%b/%h exp=1/0", imem_req_valid, imem_addr); end
        checks++; if (pc_plus_step !== 32'h4) begin failures++; $display("FAIL plus0 got=%h exp=4", pc_plus_step); end
        step();
        checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL run_addr4 got=%h exp=4", imem_addr); end
        step();
        checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL run_addr8 got=%h exp=8", imem_addr); end
    endtask

    task automatic test_stall_hold();
        imem_req_ready = 1'b0;
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL hold1 got=%b/%h exp=1/8", imem_req_valid, imem_addr); end
        stall = 1'b1; #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL hold_stall got=%b/%h exp=1/8", imem_req_valid, imem_addr); end
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL hold2 got=%b/%h exp=1/8", imem_req_valid, imem_addr); end
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL hold3 got=%b/%h exp=1/8", imem_req_valid, imem_addr); end
        imem_req_ready = 1'b1; stall = 1'b0;
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC) begin failures++; $display("FAIL after_hold got=%b/%h exp=1/c", imem_req_valid, imem_addr); end
    endtask

    task automatic test_redirect_held();
        step();
        imem_req_ready = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_target = 32'h200;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL redir_hold got=%b/%h exp=1/10", imem_req_valid, imem_addr); end
        imem_req_ready = 1'b1;
        step();
        checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL redir_pend got=%h exp=200", imem_addr); end
        imem_req_ready = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_target = 32'h300;
        step();
        redirect_valid = 1'b0; trap_req = 1'b1;
        step();
        trap_req = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h400;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL trap_hold got=%h exp=200", imem_addr); end
        imem_req_ready = 1'b1;
        step();
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL trap_pend got=%h exp=100", imem_addr); end
        redirect_valid = 1'b1; redirect_target = 32'h40;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL redir_direct got=%h exp=40", imem_addr); end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_target = 32'h202;
        step();
        redirect_valid = 1'b0;
        checks++; if (misalign_exc !== 1'b1 || misalign_addr !== 32'h202) begin failures++; $display("FAIL mis_exc got=%b/%h exp=1/202", misalign_exc, misalign_addr); end
        checks++; if (imem_addr !== 32'h44) begin failures++; $display("FAIL mis_addr got=%h exp=44", imem_addr); end
        checks++; if (d16_addr !== 32'h202 || d16_valid !== 1'b1) begin failures++; $display("FAIL ia16_addr got=%b/%h exp=1/202", d16_valid, d16_addr); end
        checks++; if (d16_mexc !== 1'b0 || d16_maddr !== 32'h0 || d16_halted !== 1'b0) begin failures++; $display("FAIL ia16_exc got=%b/%h/%b exp=0/0/0", d16_mexc, d16_maddr, d16_halted); end
        checks++; if (d16_plus !== 32'h206) begin failures++; $display("FAIL ia16_plus got=%h exp=206", d16_plus); end
        step();
        checks++; if (misalign_exc !== 1'b0 || imem_addr !== 32'h48) begin failures++; $display("FAIL mis_pulse got=%b/%h exp=0/48", misalign_exc, imem_addr); end
        redirect_valid = 1'b1; redirect_target = 32'h203; trap_req = 1'b1;
        step();
        redirect_valid = 1'b0; trap_req = 1'b0;
        checks++; if (misalign_exc !== 1'b0 || imem_addr !== 32'h100) begin failures++; $display("FAIL mis_trap got=%b/%h exp=0/100", misalign_exc, imem_addr); end
        checks++; if (d16_addr !== 32'h100) begin failures++; $display("FAIL ia16_trap got=%h exp=100", d16_addr); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC || pc_plus_step !== 32'h0) begin failures++; $display("FAIL wrap_top got=%h/%h exp=fffffffc/0", imem_addr, pc_plus_step); end
        step();
        checks++; if (imem_addr !== 32'h0 || pc_plus_step !== 32'h4) begin failures++; $display("FAIL wrap_zero got=%h/%h exp=0/4", imem_addr, pc_plus_step); end
    endtask

    task automatic test_halt();
        step();
        imem_req_ready = 1'b0;
        step();
        halt_req = 1'b1;
        step();
        checks++; if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL halt_wait got=%b/%b/%h exp=0/1/4", halted, imem_req_valid, imem_addr); end
        imem_req_ready = 1'b1;
        step();
        halt_req = 1'b0;
        checks++; if (halted !== 1'b1 || imem_req_valid !== 1'b0 || imem_addr !== 32'h8) begin failures++; $display("FAIL halt_enter got=%b/%b/%h exp=1/0/8", halted, imem_req_valid, imem_addr); end
        for (int i = 0; i < 5; i++) begin
            redirect_valid = (i == 2); redirect_target = 32'h500;
            step();
            checks++; if (halted !== 1'b1 || imem_req_valid !== 1'b0 || imem_addr !== 32'h8) begin failures++; $display("FAIL halt_cyc%0d got=%b/%b/%h exp=1/0/8", i, halted, imem_req_valid, imem_addr); end
        end
        redirect_valid = 1'b0; resume = 1'b1;
        step();
        resume = 1'b0;
        checks++; if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL resume got=%b/%b/%h exp=0/1/8", halted, imem_req_valid, imem_addr); end
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        checks++; if (halted !== 1'b1 || imem_addr !== 32'hC) begin failures++; $display("FAIL halt2 got=%b/%h exp=1/c", halted, imem_addr); end
        trap_req = 1'b1;
        step();
        trap_req = 1'b0;
        checks++; if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL halt_trap got=%b/%b/%h exp=0/1/100", halted, imem_req_valid, imem_addr); end
    endtask

    task automatic test_reset_mid_hold();
        imem_req_ready = 1'b0;
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL prehold got=%b/%h exp=1/100", imem_req_valid, imem_addr); end
        reset = 1'b1;
        step();
        reset = 1'b0; #1;
        checks++; if (imem_req_valid !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL rst_hold got=%b/%h exp=0/0", imem_req_valid, imem_addr); end
        imem_req_ready = 1'b1;
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rst_boot got=%b/%h exp=1/0", imem_req_valid, imem_addr); end
        step();
        checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL rst_next got=%h exp=4", imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stall_hold();
        test_redirect_held();
        test_misalign();
        test_wrap();
        test_halt();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
